// File: rtl/sseq_pkg.sv
// Shared definitions for the bit-serial adder transmit/collect block.
//   SSEQ_N  : default operand width
//   state_e : controller state encoding (IDLE=0, SHIFT=1, DONE=2)
package sseq_pkg;

    localparam int SSEQ_N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sseq_tx_piso_shift.sv
// N-bit parallel-in / serial-out register, LSB first.
//   clk, rst : clock and synchronous active-high reset
//   load_i   : capture d_i (wins over shift_i)
//   shift_i  : shift right by one, zero fill from the top
//   d_i      : parallel data
//   q_o      : current serial bit (register bit 0)
module piso_shift #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] d_i,
    output logic         q_o
);

    logic [N-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= d_i;
        end else if (shift_i) begin
            sr_q <= {1'b0, sr_q[N-1:1]};
        end
    end

    assign q_o = sr_q[0];

endmodule

// File: rtl/sseq_tx.sv
// Transmit/collect end of the bit-serial adder link.
// Launches two N-bit operands LSB first on X/Y, collects the returned sum
// bit Zin each cycle and presents the (N+1)-bit result on S.
//   clk, rst  : clock, synchronous active-high reset
//   start     : launch request, honoured only in IDLE
//   A, B      : operands, captured on the accepted start
//   Zin       : serial sum bit (combinational from current X/Y)
//   X, Y      : serial operand bits
//   first     : high during bit 0 (adder clears its carry)
//   busy      : high while shifting
//   done      : one-cycle pulse, S valid
//   S         : last completed result, S[N] = final carry
//   dbg_state : controller state, for observation only
//
// Handshake: start is a level request sampled on a clock edge while IDLE;
// it is neither queued nor remembered in SHIFT/DONE. busy covers the N+1
// shift cycles; done pulses for exactly one cycle after them, and S changes
// only on the edge that raises done.
module sseq_tx
    import sseq_pkg::*;
#(
    parameter int N = SSEQ_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Zin,
    output logic         X,
    output logic         Y,
    output logic         first,
    output logic         busy,
    output logic         done,
    output logic [N:0]   S,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    col_q, col_d;
    logic [N:0]    s_q, s_d;
    logic          load, shift;
    logic          a_bit, b_bit;

    piso_shift #(.N(N)) u_sr_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (A),
        .q_o     (a_bit)
    );

    piso_shift #(.N(N)) u_sr_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (B),
        .q_o     (b_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        s_d     = s_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    col_d   = '0;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                // Right-shift into the MSB: after N+1 samples the bit taken
                // in cycle 0 has reached bit 0.
                col_d = {Zin, col_q[N:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    s_d     = col_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode flops only; the flush cycle (cnt == N) forces X/Y
    // low so the adder emits its final carry as the last sum bit.
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign first     = busy && (cnt_q == '0);
    assign X         = busy && (cnt_q != LAST) && a_bit;
    assign Y         = busy && (cnt_q != LAST) && b_bit;
    assign S         = s_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sseq_tx.sv
module tb_sseq_tx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A, B;
    logic         Zin;
    logic         X, Y, first, busy, done;
    logic [N:0]   S;
    logic [1:0]   dbg_state;

    logic [N:0]   exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           done_seen = 0;
    logic [N:0]   last_sum;
    logic         carry_q;

    sseq_tx #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .Zin       (Zin),
        .X         (X),
        .Y         (Y),
        .first     (first),
        .busy      (busy),
        .done      (done),
        .S         (S),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- serial adder model ----------------
    assign Zin = X ^ Y ^ (first ? 1'b0 : carry_q);

    always @(posedge clk) begin
        if (rst) carry_q <= 1'b0;
        else     carry_q <= (X & Y) | ((X | Y) & (first ? 1'b0 : carry_q));
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse consumes one expected sum.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) check("unexpected_done", done, 0);
            else                   check("sum", S, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N:0] model_sum(input logic [N-1:0] a, input logic [N-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // One complete transfer from IDLE with per-cycle checks. If inject >= 0,
    // start is pulsed (A=B=1) in that shift cycle and must be ignored.
    task automatic run_xfer(input logic [N-1:0] a, input logic [N-1:0] b, input int inject);
        A = a;
        B = b;
        start = 1'b1;
        exp_q.push_back(model_sum(a, b));
        step();
        start = 1'b0;
        A = ~a;
        B = ~b;
        for (int i = 0; i <= N; i++) begin
            check("x_bit",  X,     (i < N) ? a[i] : 1'b0);
            check("y_bit",  Y,     (i < N) ? b[i] : 1'b0);
            check("first",  first, (i == 0));
            check("busy",   busy,  1);
            check("s_hold", S,     last_sum);
            if (i == inject) begin
                start = 1'b1;
                A = 1;
                B = 1;
            end
            step();
            if (i == inject) start = 1'b0;
        end
        check("done_pulse", done, 1);
        check("done_busy",  busy, 0);
        check("done_x",     X,    0);
        last_sum = model_sum(a, b);
        step();
        check("back_idle", dbg_state, 2'd0);
        check("done_low",  done,      0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_done, prev_done, low_run, saved;
        logic seen_busy;

        rst = 1'b1;
        start = 1'b1;
        A = 5;
        B = 3;
        last_sum = '0;
        step();
        step();
        check("rst_state", dbg_state, 2'd0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_xyf",   {X, Y, first}, 0);
        check("rst_s",     S, 0);
        rst = 1'b0;
        start = 1'b0;
        step();
        check("post_rst_idle", dbg_state, 2'd0);
        check("post_rst_busy", busy, 0);

        // Basic sums, including the carry-out case.
        run_xfer(4'd5, 4'd3, -1);
        check("sum_5_3", S, 5'b01000);
        run_xfer(4'd15, 4'd15, -1);
        check("sum_15_15", S, 5'b11110);

        // start during SHIFT is not queued.
        saved = done_seen;
        run_xfer(4'd2, 4'd3, 1);
        check("ign_sum", S, 5'd5);
        repeat (8) step();
        check("no_second_done", done_seen, saved + 1);
        check("ign_idle", dbg_state, 2'd0);

        // Reset mid-transfer.
        A = 9;
        B = 6;
        start = 1'b1;
        exp_q.push_back(model_sum(4'd9, 4'd6));
        step();
        start = 1'b0;
        step();
        step();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        check("mid_rst_xy",    {X, Y}, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_done",  done, 0);
        check("mid_rst_s",     S, 0);
        check("mid_rst_state", dbg_state, 2'd0);
        exp_q.delete();
        last_sum = '0;
        rst = 1'b0;
        step();
        run_xfer(4'd9, 4'd6, -1);
        check("sum_9_6", S, 5'd15);

        // start held high: one transfer every N+3 cycles.
        A = 7;
        B = 1;
        start = 1'b1;
        repeat (3) exp_q.push_back(model_sum(4'd7, 4'd1));
        n_done = 0;
        prev_done = -1;
        low_run = 0;
        seen_busy = 1'b0;
        step();
        for (int k = 1; k <= 40 && n_done < 3; k++) begin
            if (done) begin
                n_done++;
                if (prev_done < 0) check("held_first_latency", k, N + 2);
                else               check("held_period", k - prev_done, N + 3);
                prev_done = k;
                if (n_done == 3) start = 1'b0;
            end
            if (busy) begin
                if (low_run > 0) check("held_busy_gap", low_run, 2);
                low_run = 0;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                low_run++;
            end
            step();
        end
        check("held_done_count", n_done, 3);
        last_sum = model_sum(4'd7, 4'd1);
        step();
        check("held_s", S, 5'd8);
        check("held_idle", dbg_state, 2'd0);

        // Random operands.
        for (int r = 0; r < 8; r++) begin
            run_xfer(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)), -1);
            if ($urandom_range(0, 1) == 1) step();
        end

        repeat (2) step();
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseq_tx.md
Name: sseq_tx

Overview:
- Transmit/collect end of the team's bit-serial adder link.
- Accepts two N-bit operands in parallel on a start strobe, then serializes them LSB-first onto the X/Y lines, one bit per clock.
- Samples the returned serial sum bit Z in the same cycle and rebuilds an (N+1)-bit parallel result, including the final carry.
- Sits between the parallel datapath and the serial adder.

Parameters:
- N, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to launch a transfer; sampled only in IDLE.
- A  input  N  operand A; sampled on the accepted start.
- B  input  N  operand B; sampled on the accepted start.
- Zin  input  1  serial sum bit returned by the adder; combinational from the current X/Y.
- X  output  1  serial operand A bit, LSB first.
- Y  output  1  serial operand B bit, LSB first.
- first  output  1  high during bit 0 only; the adder uses it to force carry-in to 0.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when the result is valid.
- S  output  N+1  collected result; S[N] holds the final carry.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state=IDLE, counter=0, shift registers=0.
  - X=Y=first=busy=done=0, S=0.
  - rst has priority over every other event, including mid-transfer. A transfer interrupted by reset is abandoned, with no done pulse, and S is cleared.
- States:
  - IDLE:
    - start=1 at edge t → latch A and B into shift registers, clear counter and the collect register, go to SHIFT.
    - start=0 → stay in IDLE.
  - SHIFT:
    - Lasts exactly N+1 cycles (counter values 0..N).
    - Cycles 0..N-1: X=A_reg[cnt], Y=B_reg[cnt].
    - Cycle N is the carry-flush cycle: X=Y=0.
    - first=1 only when cnt=0. busy=1 throughout.
    - Each edge: collect register bit cnt ← Zin. Implement as a right-shift into the MSB so that after N+1 shifts bit 0 holds the LSB.
    - Leave SHIFT on the edge where cnt=N → DONE.
  - DONE:
    - One cycle: done=1, busy=0, X=Y=0.
    - S is updated on the edge entering DONE and holds until the next accepted start completes.
    - Next edge → IDLE unconditionally.
- Timing: start accepted at edge t → bit 0 is driven in cycle t+1 → done is high in cycle t+N+2 → the next start can be accepted at edge t+N+3. Back-to-back with start held high gives one transfer every N+3 cycles.
- start is ignored in SHIFT and DONE; it is not queued.
- Changes on A and B after acceptance are ignored.
- S is the previous result (or 0 after reset) until done; it is never partially updated, because the collect register is separate from S.
- X, Y and first are registered outputs. They are driven from the state/counter flops, with no combinational path from start.
- Arithmetic: S = A + B modulo 2^(N+1). This equals the exact sum and relies on the downstream carry being cleared by first.
- Counter width: clog2(N+1). No wrap-around occurs, because the counter is cleared on every accept.

Decomposition:
- Shared package sseq_pkg:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default width constant SSEQ_N=4.
- One natural sub-module: piso_shift (N-bit parallel-in/serial-out register, load/shift enable), instantiated twice for A and B.
- The FSM, counter and collector stay in the top level.

Test Plan:
- Use a bench model of the serial adder: a carry flop cleared when first=1.
- Scenarios (N=4):
  - rst held 2 cycles, then released → all outputs 0, state IDLE; start stays ignored while rst=1.
  - A=5, B=3, start for 1 cycle → X seq 1,0,1,0,0; Y seq 1,1,0,0,0; first high in the first shift cycle only; done at t+6; S=5'b01000.
  - A=15, B=15 → S=5'b11110 (30), with the final carry captured in the flush cycle.
  - start pulsed again during SHIFT with A=1, B=1 → ignored; S=original sum; no second done until a new start in IDLE.
  - rst asserted at shift cycle 2 of A=9, B=6 → next cycle X=Y=busy=0, S=0, no done; a subsequent start with A=9, B=6 gives S=15.
  - start held high with A=7, B=1 → done every 7 cycles; S=8 each time; busy low exactly 2 cycles between transfers.
